// File: rtl/rv32i_types.sv
// Shared RV32/RV64 M-extension types: funct3 op encoding, iterative unit
// FSM states and width-independent helpers.
package rv32i_types;

  localparam int unsigned M_FUNCT3_W = 3;

  typedef enum logic [2:0] {
    M_MUL    = 3'b000,
    M_MULH   = 3'b001,
    M_MULHSU = 3'b010,
    M_MULHU  = 3'b011,
    M_DIV    = 3'b100,
    M_DIVU   = 3'b101,
    M_REM    = 3'b110,
    M_REMU   = 3'b111
  } m_funct3_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } m_state_t;

  // Operand signedness {rs1 signed, rs2 signed}. Low mul is classed as signed
  // because its result does not depend on signedness.
  function automatic logic [1:0] op_signs(input logic [2:0] f);
    logic [1:0] s;
    case (f)
      M_MUL, M_MULH, M_DIV, M_REM: s = 2'b11;
      M_MULHSU:                    s = 2'b10;
      M_MULHU, M_DIVU, M_REMU:     s = 2'b00;
      default:                     s = 2'b00;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/m_div_core.sv
// Restoring unsigned divider, DIV_BPC quotient bits per busy cycle.
// start loads magnitudes; done is high during the final step cycle; quot and
// rem hold their final values until the next start.
module m_div_core #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned DIV_BPC = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            abort,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quot,
  output logic [XLEN-1:0] rem
);

  localparam int unsigned CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] STEPS   = CW'(XLEN / DIV_BPC);
  localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);

  logic [XLEN-1:0] quot_r, rem_r, divisor_r;
  logic [XLEN-1:0] quot_nxt_s, rem_nxt_s;
  logic [XLEN:0]   shift_s, diff_s;
  logic [CW-1:0]   cnt_r;
  logic            busy_r;

  // DIV_BPC restoring steps: shift in next dividend bit, subtract if it fits
  always_comb begin
    quot_nxt_s = quot_r;
    rem_nxt_s  = rem_r;
    shift_s    = {(XLEN+1){1'b0}};
    diff_s     = {(XLEN+1){1'b0}};
    for (int i = 0; i < int'(DIV_BPC); i++) begin
      shift_s = {rem_nxt_s, quot_nxt_s[XLEN-1]};
      diff_s  = shift_s - {1'b0, divisor_r};
      if (!diff_s[XLEN]) begin
        rem_nxt_s  = diff_s[XLEN-1:0];
        quot_nxt_s = {quot_nxt_s[XLEN-2:0], 1'b1};
      end else begin
        rem_nxt_s  = shift_s[XLEN-1:0];
        quot_nxt_s = {quot_nxt_s[XLEN-2:0], 1'b0};
      end
    end
  end

  // Divider iteration registers and step counter
  always_ff @(posedge clk) begin
    if (rst) begin
      quot_r    <= {XLEN{1'b0}};
      rem_r     <= {XLEN{1'b0}};
      divisor_r <= {XLEN{1'b0}};
      cnt_r     <= {CW{1'b0}};
      busy_r    <= 1'b0;
    end else if (abort) begin
      busy_r <= 1'b0;
    end else if (start) begin
      quot_r    <= dividend;
      rem_r     <= {XLEN{1'b0}};
      divisor_r <= divisor;
      cnt_r     <= STEPS;
      busy_r    <= 1'b1;
    end else if (busy_r) begin
      quot_r <= quot_nxt_s;
      rem_r  <= rem_nxt_s;
      cnt_r  <= cnt_r - CNT_ONE;
      busy_r <= (cnt_r != CNT_ONE);
    end
  end

  assign busy = busy_r;
  assign done = busy_r && (cnt_r == CNT_ONE);
  assign quot = quot_r;
  assign rem  = rem_r;

endmodule

// File: rtl/m_unit_iter.sv
// Iterative RV32M/RV64M execute unit (MUL..REMU) with valid/ready request,
// held response and flush. Optional result cache: define M_RESULT_CACHE_EN.
module m_unit_iter
  import rv32i_types::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned MUL_BPC = 2,
  parameter int unsigned DIV_BPC = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [M_FUNCT3_W-1:0] funct3,
  input  logic [XLEN-1:0]       a,
  input  logic [XLEN-1:0]       b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [XLEN-1:0]       resp_data
);

  localparam int unsigned CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   MUL_N   = CW'(XLEN / MUL_BPC);
  localparam logic [CW-1:0]   DIV_N   = CW'(XLEN / DIV_BPC);
  localparam logic [CW-1:0]   CNT_ONE = CW'(1'b1);
  localparam logic [XLEN-1:0] X_ZERO  = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] X_ONES  = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] X_MIN   = {1'b1, {(XLEN-1){1'b0}}};

  // Pick the architectural result of an op from fixed-up datapath values
  function automatic logic [XLEN-1:0] sel_result(input logic [2:0] f,
                                                  input logic [2*XLEN-1:0] p,
                                                  input logic [XLEN-1:0] q,
                                                  input logic [XLEN-1:0] r);
    logic [XLEN-1:0] res;
    case (f)
      M_MUL:                     res = p[XLEN-1:0];
      M_MULH, M_MULHSU, M_MULHU: res = p[2*XLEN-1:XLEN];
      M_DIV, M_DIVU:             res = q;
      M_REM, M_REMU:             res = r;
      default:                   res = X_ZERO;
    endcase
    return res;
  endfunction

  m_state_t          state_r, state_nxt_s;
  logic [2:0]        op_r;
  logic              neg_r, rneg_r;
  logic [CW-1:0]     cnt_r;
  logic [XLEN-1:0]   mcand_r;
  logic [2*XLEN-1:0] prod_r;
  logic [XLEN-1:0]   resp_data_r;
  logic              req_ready_r, resp_valid_r;

  logic              accept_s, fast_s, div_start_s, run_last_s, fix_done_s;
  logic [1:0]        sgn_s;
  logic              a_neg_s, b_neg_s;
  logic [XLEN-1:0]   a_mag_s, b_mag_s;
  logic              div_zero_s, div_ovf_s, special_s;
  logic [XLEN-1:0]   special_res_s, fast_res_s, fix_res_s;
  logic              hit_s;
  logic [XLEN-1:0]   hit_res_s;
  logic [XLEN+MUL_BPC-1:0] mcand_ext_s, digit_ext_s, mul_sum_s;
  logic [2*XLEN-1:0] prod_fix_s;
  logic [XLEN-1:0]   quot_fix_s, rem_fix_s;
  logic              div_busy_s, div_done_s;
  logic [XLEN-1:0]   div_quot_s, div_rem_s;

  // Request decode: signs, magnitudes and the divide corner cases
  assign sgn_s      = op_signs(funct3);
  assign a_neg_s    = sgn_s[1] & a[XLEN-1];
  assign b_neg_s    = sgn_s[0] & b[XLEN-1];
  assign a_mag_s    = a_neg_s ? (X_ZERO - a) : a;
  assign b_mag_s    = b_neg_s ? (X_ZERO - b) : b;
  assign div_zero_s = funct3[2] && (b == X_ZERO);
  assign div_ovf_s  = funct3[2] && sgn_s[0] && (a == X_MIN) && (b == X_ONES);
  assign special_s  = div_zero_s || div_ovf_s;

  // Fixed results for divide-by-zero and signed overflow
  always_comb begin
    special_res_s = X_ZERO;
    if (div_zero_s) begin
      if (funct3[1]) special_res_s = a;
      else           special_res_s = X_ONES;
    end else if (div_ovf_s) begin
      if (funct3[1]) special_res_s = X_ZERO;
      else           special_res_s = X_MIN;
    end else begin
      special_res_s = X_ZERO;
    end
  end

  assign fast_res_s = special_s ? special_res_s : hit_res_s;

  // Shift-add multiplier step: multiplier sits in the low half of prod_r
  assign mcand_ext_s = {{MUL_BPC{1'b0}}, mcand_r};
  assign digit_ext_s = {{XLEN{1'b0}}, prod_r[MUL_BPC-1:0]};
  assign mul_sum_s   = {{MUL_BPC{1'b0}}, prod_r[2*XLEN-1:XLEN]} + (mcand_ext_s * digit_ext_s);

  // Sign fix-up applied in FIX
  assign prod_fix_s = neg_r  ? ({(2*XLEN){1'b0}} - prod_r) : prod_r;
  assign quot_fix_s = neg_r  ? (X_ZERO - div_quot_s) : div_quot_s;
  assign rem_fix_s  = rneg_r ? (X_ZERO - div_rem_s)  : div_rem_s;
  assign fix_res_s  = sel_result(op_r, prod_fix_s, quot_fix_s, rem_fix_s);
  assign fix_done_s = (state_r == FIX) && !flush;

  // Leave RUN on the last step; an idle divider also ends the op so it cannot hang
  assign run_last_s = op_r[2] ? (div_done_s || !div_busy_s) : (cnt_r == CNT_ONE);

  m_div_core #(.XLEN(XLEN), .DIV_BPC(DIV_BPC)) u_div (
    .clk      (clk),
    .rst      (rst),
    .abort    (flush),
    .start    (div_start_s),
    .dividend (a_mag_s),
    .divisor  (b_mag_s),
    .busy     (div_busy_s),
    .done     (div_done_s),
    .quot     (div_quot_s),
    .rem      (div_rem_s)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nxt_s;
  end

  // Next state, accept and fast-path decode; flush overrides everything
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    fast_s      = 1'b0;
    div_start_s = 1'b0;
    if (flush) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid && req_ready_r) begin
            accept_s = 1'b1;
            if (special_s || hit_s) begin
              fast_s      = 1'b1;
              state_nxt_s = DONE;
            end else begin
              div_start_s = funct3[2];
              state_nxt_s = RUN;
            end
          end else begin
            state_nxt_s = IDLE;
          end
        end
        RUN: begin
          if (run_last_s) state_nxt_s = FIX;
          else            state_nxt_s = RUN;
        end
        FIX:  state_nxt_s = DONE;
        DONE: begin
          if (resp_ready) state_nxt_s = IDLE;
          else            state_nxt_s = DONE;
        end
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Operand capture on accept and multiplier iteration during RUN
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r    <= 3'b000;
      neg_r   <= 1'b0;
      rneg_r  <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      mcand_r <= X_ZERO;
      prod_r  <= {(2*XLEN){1'b0}};
    end else if (accept_s) begin
      op_r    <= funct3;
      neg_r   <= a_neg_s ^ b_neg_s;
      rneg_r  <= a_neg_s;
      cnt_r   <= funct3[2] ? DIV_N : MUL_N;
      mcand_r <= a_mag_s;
      prod_r  <= {X_ZERO, b_mag_s};
    end else if (state_r == RUN) begin
      cnt_r <= cnt_r - CNT_ONE;
      if (!op_r[2]) prod_r <= {mul_sum_s, prod_r[XLEN-1:MUL_BPC]};
    end
  end

  // Registered handshake outputs and held response data
  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_data_r  <= X_ZERO;
    end else begin
      req_ready_r  <= (state_nxt_s == IDLE);
      resp_valid_r <= (state_nxt_s == DONE);
      if (fast_s)          resp_data_r <= fast_res_s;
      else if (fix_done_s) resp_data_r <= fix_res_s;
    end
  end

`ifdef M_RESULT_CACHE_EN
  logic              c_valid_r, c_div_r;
  logic [1:0]        c_sgn_r;
  logic [XLEN-1:0]   c_a_r, c_b_r, c_quot_r, c_rem_r, a_r, b_r;
  logic [2*XLEN-1:0] c_prod_r;

  // Raw operand copy used as the cache tag when the op completes
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r <= X_ZERO;
      b_r <= X_ZERO;
    end else if (accept_s) begin
      a_r <= a;
      b_r <= b;
    end
  end

  // Single-entry result cache, refilled by every normal completion
  always_ff @(posedge clk) begin
    if (rst) begin
      c_valid_r <= 1'b0;
      c_div_r   <= 1'b0;
      c_sgn_r   <= 2'b00;
      c_a_r     <= X_ZERO;
      c_b_r     <= X_ZERO;
      c_prod_r  <= {(2*XLEN){1'b0}};
      c_quot_r  <= X_ZERO;
      c_rem_r   <= X_ZERO;
    end else if (fix_done_s) begin
      c_valid_r <= 1'b1;
      c_div_r   <= op_r[2];
      c_sgn_r   <= op_signs(op_r);
      c_a_r     <= a_r;
      c_b_r     <= b_r;
      c_prod_r  <= prod_fix_s;
      c_quot_r  <= quot_fix_s;
      c_rem_r   <= rem_fix_s;
    end
  end

  assign hit_s = c_valid_r && (a == c_a_r) && (b == c_b_r) &&
                 (funct3[2] == c_div_r) && (sgn_s == c_sgn_r);
  assign hit_res_s = sel_result(funct3, c_prod_r, c_quot_r, c_rem_r);
`else
  assign hit_s     = 1'b0;
  assign hit_res_s = X_ZERO;
`endif

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_data  = resp_data_r;

endmodule
